// File: rtl/stream_init_loader.sv
// Streams source words into the per-channel stream buffers while broadcasting a hash-table clear.
// Optional checksum output of accepted words: define STREAM_INIT_CHECKSUM_EN.
module stream_init_loader #(
  parameter int LENGTH_ARRAY     = 100,
  parameter int NUM_CHANNEL      = 3,
  parameter int DATA_INDEX_WIDTH = 32,
  parameter int BIT_ON_TAILS     = 7,
  localparam int AW = $clog2(LENGTH_ARRAY + 1),
  localparam int HW = BIT_ON_TAILS + 1,
  localparam int CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          DataRequest,
  input  logic                          SrcValid,
  input  logic [DATA_INDEX_WIDTH-1:0]   SrcData,
  output logic                          SrcReady,
  output logic                          WrInitStreamData,
  output logic [CW-1:0]                 ChanInitStreamData,
  output logic [AW-1:0]                 AddrInitStreamData,
  output logic [DATA_INDEX_WIDTH-1:0]   InitStreamData,
  output logic                          WrInitHash,
  output logic [HW-1:0]                 AddrInitHashOccurr,
  output logic [2*DATA_INDEX_WIDTH-1:0] InitHashOccurr,
  output logic                          CacheEnough,
  output logic                          Busy
`ifdef STREAM_INIT_CHECKSUM_EN
  ,
  output logic [DATA_INDEX_WIDTH-1:0]   LoadChecksum
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW-1:0] LAST_WORD = AW'(LENGTH_ARRAY - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNEL - 1);
  localparam logic [HW-1:0] HASH_N    = HW'(1 << BIT_ON_TAILS);

  logic [1:0]                  state_q, state_d;
  logic [AW-1:0]               wcnt_q, wcnt_d;
  logic [CW-1:0]               chan_q, chan_d;
  logic [HW-1:0]               hcnt_q, hcnt_d;
  logic                        sdone_q, sdone_d;
  logic                        wr_stream_q, wr_stream_d;
  logic [CW-1:0]               chan_out_q, chan_out_d;
  logic [AW-1:0]               addr_out_q, addr_out_d;
  logic [DATA_INDEX_WIDTH-1:0] data_out_q, data_out_d;
  logic                        wr_hash_q, wr_hash_d;
  logic [HW-1:0]               haddr_q, haddr_d;
  logic                        cache_q, cache_d;

  logic src_ready;
  logic accept;
  logic hash_done;

  assign src_ready = (state_q == RUN) && !sdone_q;
  // A word offered in the cycle DataRequest drops is refused even though SrcReady is still high.
  assign accept    = DataRequest && SrcValid && src_ready;
  assign hash_done = (hcnt_q == HASH_N);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    chan_d      = chan_q;
    hcnt_d      = hcnt_q;
    sdone_d     = sdone_q;
    wr_stream_d = 1'b0;
    chan_out_d  = chan_out_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    wr_hash_d   = 1'b0;
    haddr_d     = haddr_q;
    if (!DataRequest) begin
      state_d = IDLE;
      wcnt_d  = '0;
      chan_d  = '0;
      hcnt_d  = '0;
      sdone_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (sdone_q && hash_done) begin
            state_d = DONE;
          end else begin
            if (accept) begin
              wr_stream_d = 1'b1;
              chan_out_d  = chan_q;
              addr_out_d  = wcnt_q;
              data_out_d  = SrcData;
              if (wcnt_q == LAST_WORD) begin
                wcnt_d = '0;
                if (chan_q == LAST_CHAN) sdone_d = 1'b1;
                else                     chan_d  = chan_q + CW'(1);
              end else begin
                wcnt_d = wcnt_q + AW'(1);
              end
            end
            // Hash clear advances every RUN cycle regardless of source stalls.
            if (!hash_done) begin
              wr_hash_d = 1'b1;
              haddr_d   = hcnt_q;
              hcnt_d    = hcnt_q + HW'(1);
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    cache_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      chan_q      <= '0;
      hcnt_q      <= '0;
      sdone_q     <= 1'b0;
      wr_stream_q <= 1'b0;
      chan_out_q  <= '0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      wr_hash_q   <= 1'b0;
      haddr_q     <= '0;
      cache_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      chan_q      <= chan_d;
      hcnt_q      <= hcnt_d;
      sdone_q     <= sdone_d;
      wr_stream_q <= wr_stream_d;
      chan_out_q  <= chan_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      wr_hash_q   <= wr_hash_d;
      haddr_q     <= haddr_d;
      cache_q     <= cache_d;
    end
  end

  assign SrcReady           = src_ready;
  assign WrInitStreamData   = wr_stream_q;
  assign ChanInitStreamData = chan_out_q;
  assign AddrInitStreamData = addr_out_q;
  assign InitStreamData     = data_out_q;
  assign WrInitHash         = wr_hash_q;
  assign AddrInitHashOccurr = haddr_q;
  assign InitHashOccurr     = '0;
  assign CacheEnough        = cache_q;
  assign Busy               = (state_q == RUN);

`ifdef STREAM_INIT_CHECKSUM_EN
  logic [DATA_INDEX_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (!DataRequest) sum_d = '0;
    else if (accept)  sum_d = sum_q + SrcData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign LoadChecksum = sum_q;
`else
  // No checksum datapath in this build.
`endif

endmodule

// File: tb/tb_stream_init_loader.sv
// Bench for stream_init_loader: fixed vectors, hand sequences and random traffic vs a word/entry-count model.
module tb_stream_init_loader;
  localparam int L  = 4;
  localparam int N  = 3;
  localparam int B  = 3;
  localparam int DW = 32;
  localparam int NL = L * N;
  localparam int H  = 1 << B;
  localparam int AW = $clog2(L + 1);
  localparam int HW = B + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic DataRequest = 1'b0;
  logic SrcValid = 1'b0;
  logic [DW-1:0] SrcData = '0;
  logic SrcReady, WrInitStreamData, WrInitHash, CacheEnough, Busy;
  logic [CW-1:0] ChanInitStreamData;
  logic [AW-1:0] AddrInitStreamData;
  logic [DW-1:0] InitStreamData;
  logic [HW-1:0] AddrInitHashOccurr;
  logic [2*DW-1:0] InitHashOccurr;
`ifdef STREAM_INIT_CHECKSUM_EN
  logic [DW-1:0] LoadChecksum;
`endif

  stream_init_loader #(
    .LENGTH_ARRAY(L), .NUM_CHANNEL(N), .DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(B)
  ) dut (
    .clk(clk), .rst(rst), .DataRequest(DataRequest), .SrcValid(SrcValid), .SrcData(SrcData),
    .SrcReady(SrcReady), .WrInitStreamData(WrInitStreamData),
    .ChanInitStreamData(ChanInitStreamData), .AddrInitStreamData(AddrInitStreamData),
    .InitStreamData(InitStreamData), .WrInitHash(WrInitHash),
    .AddrInitHashOccurr(AddrInitHashOccurr), .InitHashOccurr(InitHashOccurr),
    .CacheEnough(CacheEnough), .Busy(Busy)
`ifdef STREAM_INIT_CHECKSUM_EN
    , .LoadChecksum(LoadChecksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: words accepted so far (k), hash entries cleared (h), run/done flags.
  bit m_run, m_done;
  int m_k, m_h;
  logic e_wr, e_hwr, e_ce, e_busy, e_ready;
  int e_chan, e_addr, e_haddr;
  logic [DW-1:0] e_data, e_sum;

  int cyc, n_wr, n_hwr, last_wr, first_h, last_h, ce_cyc;

  typedef struct {
    int dr; int v; logic [31:0] d;
    int wr; int ch; int ad; logic [31:0] dat;
    int hwr; int ha; int ce; int rdy;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_k = 0; m_h = 0;
    e_wr = 0; e_hwr = 0; e_ce = 0; e_busy = 0; e_ready = 0;
    e_chan = 0; e_addr = 0; e_haddr = 0; e_data = '0; e_sum = '0;
  endtask

  task automatic model_step(input logic dr, input logic v, input logic [DW-1:0] d);
    bit rdy;
    rdy = m_run && (m_k < NL);
    e_wr = 0; e_hwr = 0;
    if (!dr) begin
      m_run = 0; m_done = 0; m_k = 0; m_h = 0; e_sum = '0;
    end else if (m_run) begin
      if (m_k == NL && m_h == H) begin
        m_run = 0; m_done = 1;
      end else begin
        if (v && rdy) begin
          e_wr = 1; e_chan = m_k / L; e_addr = m_k % L; e_data = d;
          e_sum = e_sum + d; m_k++;
        end
        if (m_h < H) begin
          e_hwr = 1; e_haddr = m_h; m_h++;
        end
      end
    end else if (!m_done) begin
      m_run = 1;
    end
    e_ce = m_done; e_busy = m_run; e_ready = m_run && (m_k < NL);
  endtask

  task automatic check_all();
    chk("wr_stream", 32'(WrInitStreamData), 32'(e_wr));
    chk("chan", 32'(ChanInitStreamData), 32'(e_chan));
    chk("addr", 32'(AddrInitStreamData), 32'(e_addr));
    chk("data", InitStreamData, e_data);
    chk("wr_hash", 32'(WrInitHash), 32'(e_hwr));
    chk("hash_addr", 32'(AddrInitHashOccurr), 32'(e_haddr));
    chk("hash_data", InitHashOccurr[31:0] | InitHashOccurr[63:32], 32'd0);
    chk("cache_enough", 32'(CacheEnough), 32'(e_ce));
    chk("busy", 32'(Busy), 32'(e_busy));
    chk("src_ready", 32'(SrcReady), 32'(e_ready));
`ifdef STREAM_INIT_CHECKSUM_EN
    chk("checksum", LoadChecksum, e_sum);
`endif
  endtask

  task automatic clear_stats();
    n_wr = 0; n_hwr = 0; last_wr = -1; first_h = -1; last_h = -1; ce_cyc = -1;
  endtask

  task automatic cycle(input logic dr, input logic v, input logic [DW-1:0] d);
    DataRequest = dr; SrcValid = v; SrcData = d;
    model_step(dr, v, d);
    @(posedge clk); #1;
    cyc++;
    check_all();
    if (WrInitStreamData) begin n_wr++; last_wr = cyc; end
    if (WrInitHash) begin n_hwr++; if (first_h < 0) first_h = cyc; last_h = cyc; end
    if (CacheEnough && ce_cyc < 0) ce_cyc = cyc;
  endtask

  // mode 0: SrcValid always high; mode 1: toggles 1,0,1,0 per cycle.
  task automatic run_until_ce(input int mode, input int bound);
    int c;
    c = 0;
    while (!CacheEnough && c < bound) begin
      cycle(1'b1, (mode == 0) ? 1'b1 : ((c % 2) == 0), DW'(m_k + 1));
      c++;
    end
    if (!CacheEnough) chk("timeout_cache_enough", 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0] = '{1, 1, 32'd1, 0, 0, 0, 32'd0, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 32'd1, 1, 0, 0, 32'd1, 1, 0, 0, 1};
    tbl[2] = '{1, 1, 32'd2, 1, 0, 1, 32'd2, 1, 1, 0, 1};
    tbl[3] = '{1, 1, 32'd3, 1, 0, 2, 32'd3, 1, 2, 0, 1};
    tbl[4] = '{1, 1, 32'd4, 1, 0, 3, 32'd4, 1, 3, 0, 1};
    tbl[5] = '{1, 1, 32'd5, 1, 1, 0, 32'd5, 1, 4, 0, 1};

    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #6 rst = 1'b1;

    // Continuous source: fixed vectors for the first cycles, then run to completion.
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].dr[0], tbl[i].v[0], tbl[i].d);
      chk("tbl_wr", 32'(WrInitStreamData), 32'(tbl[i].wr));
      chk("tbl_chan", 32'(ChanInitStreamData), 32'(tbl[i].ch));
      chk("tbl_addr", 32'(AddrInitStreamData), 32'(tbl[i].ad));
      chk("tbl_data", InitStreamData, tbl[i].dat);
      chk("tbl_hwr", 32'(WrInitHash), 32'(tbl[i].hwr));
      chk("tbl_haddr", 32'(AddrInitHashOccurr), 32'(tbl[i].ha));
      chk("tbl_ce", 32'(CacheEnough), 32'(tbl[i].ce));
      chk("tbl_ready", 32'(SrcReady), 32'(tbl[i].rdy));
    end
    run_until_ce(0, 40);
    chk("a_n_wr", 32'(n_wr), 32'd12);
    chk("a_n_hwr", 32'(n_hwr), 32'd8);
    chk("a_ce_after_last_wr", 32'(ce_cyc), 32'(last_wr + 1));
    chk("a_last_data", InitStreamData, 32'd12);
    repeat (3) cycle(1'b1, 1'b1, 32'hDEAD);
    chk("a_done_holds", 32'(CacheEnough), 32'd1);

    // Toggling source valid.
    cycle(1'b0, 1'b0, '0);
    chk("b_ce_fall", 32'(CacheEnough), 32'd0);
    clear_stats();
    run_until_ce(1, 80);
    chk("b_n_wr", 32'(n_wr), 32'd12);
    chk("b_n_hwr", 32'(n_hwr), 32'd8);
    chk("b_hash_span", 32'(last_h - first_h + 1), 32'd8);
    chk("b_ce_after_last_wr", 32'(ce_cyc), 32'(last_wr + 1));

    // Abort after five stream writes, then restart from scratch.
    cycle(1'b0, 1'b0, '0);
    clear_stats();
    for (int c = 0; c < 20 && n_wr < 5; c++) cycle(1'b1, 1'b1, DW'(m_k + 1));
    chk("c_five_writes", 32'(n_wr), 32'd5);
    cycle(1'b0, 1'b1, 32'h77);
    chk("c_abort_wr", 32'(WrInitStreamData), 32'd0);
    chk("c_abort_hwr", 32'(WrInitHash), 32'd0);
    chk("c_abort_ready", 32'(SrcReady), 32'd0);
    cycle(1'b1, 1'b1, 32'd1);
    cycle(1'b1, 1'b1, 32'd1);
    chk("c_restart_wr", 32'(WrInitStreamData), 32'd1);
    chk("c_restart_chan", 32'(ChanInitStreamData), 32'd0);
    chk("c_restart_addr", 32'(AddrInitStreamData), 32'd0);
    chk("c_restart_haddr", 32'(AddrInitHashOccurr), 32'd0);
    run_until_ce(0, 40);

    // Asynchronous reset mid-run.
    cycle(1'b0, 1'b0, '0);
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1, DW'(m_k + 1));
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b1;
    clear_stats();
    run_until_ce(0, 40);
    chk("d_n_wr", 32'(n_wr), 32'd12);
    chk("d_n_hwr", 32'(n_hwr), 32'd8);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++)
      cycle($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), DW'($urandom));

`ifdef STREAM_INIT_CHECKSUM_EN
    // All-ones words wrap the checksum.
    cycle(1'b0, 1'b0, '0);
    run_until_ce(0, 40);
    cycle(1'b0, 1'b0, '0);
    for (int c = 0; c < 40 && !CacheEnough; c++) cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("e_checksum_wrap", LoadChecksum, 32'hFFFF_FFF4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
